trigger_ctrl: RTL and testbench

// Self-trigger sequencer for the ADC-to-DMA acquisition datapath. Watches the RF Data Converter

---
 rtl/trigger_ctrl.sv | 153 +++++++++++++++
 tb/tb_trigger_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: self-trigger sequencer for the ADC-to-DMA acquisition datapath.
// Opens a window on a threshold crossing and closes it on post-length, window cap or FIFO-full abort.
module trigger_ctrl #(
    parameter int THRESHOLD            = 10,
    parameter int PRE_ACQUI_LEN        = 12,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int ACQUI_LEN            = 100,
    parameter int HOLDOFF_LEN          = 12,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESETN,
    input  logic                          ENABLE,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TREADY,
    input  logic                          FIFO_FULL,
    output logic                          START_TRG,
    output logic                          FINALIZE_TRG,
    output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    output logic                          BUSY,
    output logic [31:0]                   EVENT_CNT,
    output logic [15:0]                   DROP_CNT
);

    localparam int NS      = S_AXIS_TDATA_WIDTH / 16;
    localparam int THR_INT = (THRESHOLD * (1 << (ADC_RESOLUTION_WIDTH - 1))) / 100;
    localparam logic signed [ADC_RESOLUTION_WIDTH-1:0] THR_CODE = THR_INT[ADC_RESOLUTION_WIDTH-1:0];
    // Holdoff must cover the pre-trigger depth, so a shorter setting is clamped up to it.
    localparam int HOLD_LEN_EFF = (HOLDOFF_LEN < PRE_ACQUI_LEN) ? PRE_ACQUI_LEN : HOLDOFF_LEN;
    localparam int WIN_W  = $clog2(ACQUI_LEN + 1);
    localparam int POST_W = $clog2(POST_ACQUI_LEN + 1);
    localparam int HOLD_W = $clog2(HOLD_LEN_EFF + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACQUIRE,
        POST,
        CLOSE,
        HOLDOFF
    } state_t;

    state_t                      state;
    logic [WIN_W-1:0]            win_cnt;
    logic [POST_W-1:0]           post_cnt;
    logic [HOLD_W-1:0]           hold_cnt;
    logic [TIME_STAMP_WIDTH-1:0] ts_cnt;
    logic                        beat;
    logic                        over_thr;
    logic                        hit;
    logic                        win_full;
    logic                        post_done;
    logic                        hold_done;
    logic                        unused_tdata;

    // Upper nibble of each 16-bit lane carries no sample bits.
    assign unused_tdata = ^S_AXIS_TDATA;

    always_comb begin
        over_thr = 1'b0;
        for (int unsigned k = 0; k < NS; k++) begin
            if ($signed(S_AXIS_TDATA[16*k +: ADC_RESOLUTION_WIDTH]) > THR_CODE) begin
                over_thr = 1'b1;
            end
        end
    end

    assign beat      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign hit       = beat & over_thr;
    assign win_full  = (win_cnt == WIN_W'(ACQUI_LEN));
    assign post_done = (post_cnt == POST_W'(POST_ACQUI_LEN));
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_LEN_EFF - 1));

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state        <= IDLE;
            win_cnt      <= '0;
            post_cnt     <= '0;
            hold_cnt     <= '0;
            ts_cnt       <= '0;
            START_TRG    <= 1'b0;
            FINALIZE_TRG <= 1'b0;
            TIME_STAMP   <= '0;
            BUSY         <= 1'b0;
            EVENT_CNT    <= '0;
            DROP_CNT     <= '0;
        end else begin
            ts_cnt <= ts_cnt + TIME_STAMP_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (hit && ENABLE) begin
                        if (FIFO_FULL) begin
                            if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + 16'd1;
                        end else begin
                            state      <= ACQUIRE;
                            START_TRG  <= 1'b1;
                            BUSY       <= 1'b1;
                            TIME_STAMP <= ts_cnt;
                            win_cnt    <= WIN_W'(1);
                            post_cnt   <= '0;
                        end
                    end
                end
                ACQUIRE, POST: begin
                    // Abort beats everything, then the window cap beats a re-trigger.
                    if (FIFO_FULL) begin
                        state        <= CLOSE;
                        START_TRG    <= 1'b0;
                        FINALIZE_TRG <= 1'b1;
                        if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + 16'd1;
                    end else if (beat) begin
                        if (win_full || (!hit && post_done)) begin
                            state        <= CLOSE;
                            START_TRG    <= 1'b0;
                            FINALIZE_TRG <= 1'b1;
                            EVENT_CNT    <= EVENT_CNT + 32'd1;
                        end else if (hit) begin
                            state    <= ACQUIRE;
                            win_cnt  <= win_cnt + WIN_W'(1);
                            post_cnt <= '0;
                        end else begin
                            state    <= POST;
                            win_cnt  <= win_cnt + WIN_W'(1);
                            post_cnt <= post_cnt + POST_W'(1);
                        end
                    end
                end
                CLOSE: begin
                    state        <= HOLDOFF;
                    FINALIZE_TRG <= 1'b0;
                    hold_cnt     <= '0;
                end
                HOLDOFF: begin
                    if (beat) begin
                        if (hold_done) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Bench for trigger_ctrl: window-level reference model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_trigger_ctrl;

    localparam int NS       = 8;
    localparam int THR_CODE = 204;
    localparam int POST_LEN = 38;
    localparam int ACQ_LEN  = 100;
    localparam int HOLD_LEN = 12;

    logic         AXIS_ACLK = 1'b0;
    logic         AXIS_ARESETN = 1'b0;
    logic         ENABLE = 1'b0;
    logic [127:0] S_AXIS_TDATA = '0;
    logic         S_AXIS_TVALID = 1'b0;
    logic         S_AXIS_TREADY = 1'b0;
    logic         FIFO_FULL = 1'b0;
    logic         START_TRG;
    logic         FINALIZE_TRG;
    logic [15:0]  TIME_STAMP;
    logic         BUSY;
    logic [31:0]  EVENT_CNT;
    logic [15:0]  DROP_CNT;

    int samp[NS];
    int checks = 0;
    int failures = 0;

    // Reference model state: what a window looks like, not how the FSM encodes it.
    bit          m_open = 0;
    bit          m_fin = 0;
    bit          m_busy = 0;
    int          m_win = 0;
    int          m_since = 0;
    int          m_hold_left = 0;
    logic [15:0] m_ts = '0;
    logic [15:0] m_stamp = '0;
    logic [31:0] m_ev = '0;
    logic [15:0] m_drop = '0;

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    trigger_ctrl #(
        .THRESHOLD(10), .PRE_ACQUI_LEN(12), .POST_ACQUI_LEN(38), .ACQUI_LEN(100),
        .HOLDOFF_LEN(12), .TIME_STAMP_WIDTH(16), .ADC_RESOLUTION_WIDTH(12), .S_AXIS_TDATA_WIDTH(128)
    ) dut (
        .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN), .ENABLE(ENABLE),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .FIFO_FULL(FIFO_FULL), .START_TRG(START_TRG), .FINALIZE_TRG(FINALIZE_TRG),
        .TIME_STAMP(TIME_STAMP), .BUSY(BUSY), .EVENT_CNT(EVENT_CNT), .DROP_CNT(DROP_CNT)
    );

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit any_over();
        for (int k = 0; k < NS; k++) if (samp[k] > THR_CODE) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_open = 0; m_fin = 0; m_busy = 0; m_win = 0; m_since = 0; m_hold_left = 0;
        m_ts = '0; m_stamp = '0; m_ev = '0; m_drop = '0;
    endtask

    task automatic model_step();
        bit          beat;
        bit          hit;
        bit          closing;
        logic [15:0] ts_now;
        beat    = S_AXIS_TVALID && S_AXIS_TREADY;
        hit     = beat && any_over();
        ts_now  = m_ts;
        m_ts    = m_ts + 16'd1;
        closing = 0;
        if (m_fin) begin
            m_fin       = 0;
            m_hold_left = HOLD_LEN;
        end else if (m_hold_left > 0) begin
            if (beat) begin
                m_hold_left--;
                if (m_hold_left == 0) m_busy = 0;
            end
        end else if (m_open) begin
            if (FIFO_FULL) begin
                closing = 1;
                if (m_drop != 16'hFFFF) m_drop++;
            end else if (beat) begin
                if (m_win == ACQ_LEN) begin
                    closing = 1; m_ev++;
                end else if (hit) begin
                    m_win++; m_since = 0;
                end else if (m_since == POST_LEN) begin
                    closing = 1; m_ev++;
                end else begin
                    m_win++; m_since++;
                end
            end
            if (closing) begin
                m_open = 0; m_fin = 1;
            end
        end else if (hit && ENABLE) begin
            if (FIFO_FULL) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                m_open = 1; m_win = 1; m_since = 0; m_stamp = ts_now; m_busy = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge AXIS_ACLK or negedge AXIS_ARESETN);
        if (!AXIS_ARESETN) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge AXIS_ACLK);
        if (AXIS_ARESETN) begin
            checks++;
            if (START_TRG !== m_open || FINALIZE_TRG !== m_fin || BUSY !== m_busy ||
                TIME_STAMP !== m_stamp || EVENT_CNT !== m_ev || DROP_CNT !== m_drop) begin
                failures++;
                $display("FAIL cycle_model t=%0t got start=%b fin=%b busy=%b ts=%h ev=%0d drop=%0d expected start=%b fin=%b busy=%b ts=%h ev=%0d drop=%0d",
                         $time, START_TRG, FINALIZE_TRG, BUSY, TIME_STAMP, EVENT_CNT, DROP_CNT,
                         m_open, m_fin, m_busy, m_stamp, m_ev, m_drop);
                if (failures >= 50) finish_run();
            end
        end
    end

    // Drive one clock's worth of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input int val, input int lane, input bit v, input bit r, input bit ff);
        for (int k = 0; k < NS; k++) samp[k] = 0;
        samp[lane] = val;
        for (int k = 0; k < NS; k++) S_AXIS_TDATA[16*k +: 16] = 16'(samp[k]);
        S_AXIS_TVALID = v;
        S_AXIS_TREADY = r;
        FIFO_FULL     = ff;
        @(posedge AXIS_ACLK);
        #1;
    endtask

    task automatic idle_beat();
        step(0, 0, 1, 1, 0);
    endtask

    task automatic hit_beat();
        step(205, 0, 1, 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && BUSY; i++) idle_beat();
        chk("wait_idle_busy", BUSY, 0);
    endtask

    initial begin
        int          n;
        int          k;
        int          total;
        logic [15:0] stamp1;
        logic [15:0] stamp_exp;

        ENABLE = 1'b1;
        for (int i = 0; i < NS; i++) samp[i] = 0;
        repeat (3) @(posedge AXIS_ACLK);
        #1;
        chk("rst_start", START_TRG, 0);
        chk("rst_fin", FINALIZE_TRG, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ts", TIME_STAMP, 0);
        chk("rst_ev", EVENT_CNT, 0);
        chk("rst_drop", DROP_CNT, 0);
        AXIS_ARESETN = 1'b1;

        // Single hit at ts 0x0123: one hit beat plus 38 post beats.
        for (int i = 0; i < 400 && m_ts != 16'h0123; i++) idle_beat();
        hit_beat();
        chk("t2_start", START_TRG, 1);
        chk("t2_stamp", TIME_STAMP, 16'h0123);
        n = 0;
        while (START_TRG && n < 200) begin n++; idle_beat(); end
        chk("t2_start_len", n, 39);
        chk("t2_fin_hi", FINALIZE_TRG, 1);
        chk("t2_ev", EVENT_CNT, 1);
        idle_beat();
        chk("t2_fin_pulse", FINALIZE_TRG, 0);
        wait_idle();

        // Threshold boundary, negative samples, ENABLE low, no-beat.
        step(204, 3, 1, 1, 0);
        step(-2000, 5, 1, 1, 0);
        idle_beat();
        chk("t3_no_trig", BUSY, 0);
        ENABLE = 1'b0;
        step(205, 0, 1, 1, 0);
        idle_beat();
        chk("t3_disabled", BUSY, 0);
        ENABLE = 1'b1;
        step(205, 0, 0, 1, 0);
        chk("t3_no_beat", BUSY, 0);
        step(205, 7, 1, 1, 0);
        chk("t3_trig", START_TRG, 1);
        wait_idle();
        chk("t3_ev", EVENT_CNT, 2);

        // FIFO_FULL abort at window beat 10, then a refused trigger in IDLE.
        hit_beat();
        repeat (9) hit_beat();
        step(0, 0, 1, 1, 1);
        chk("t5_fin", FINALIZE_TRG, 1);
        chk("t5_start", START_TRG, 0);
        chk("t5_drop", DROP_CNT, 1);
        chk("t5_ev", EVENT_CNT, 2);
        wait_idle();
        step(300, 2, 1, 1, 1);
        chk("t5_idle_drop", DROP_CNT, 2);
        chk("t5_idle_busy", BUSY, 0);

        // 150 consecutive hit beats: capped window, holdoff, re-trigger.
        hit_beat();
        stamp1 = TIME_STAMP;
        total = 1;
        n = 0;
        while (START_TRG && n < 200) begin n++; hit_beat(); end
        total += n;
        chk("t4_cap_len", n, 100);
        chk("t4_ev", EVENT_CNT, 3);
        k = 0;
        while (!START_TRG && k < 50) begin k++; hit_beat(); end
        total += k;
        stamp_exp = stamp1 + 16'd114;
        chk("t4_gap", k, 14);
        chk("t4_restamp", TIME_STAMP, stamp_exp);
        chk("t4_drop", DROP_CNT, 2);
        while (total < 150) begin hit_beat(); total++; end
        wait_idle();
        chk("t4_ev_end", EVENT_CNT, 4);

        // Asynchronous reset in the middle of a window (win_cnt = 40).
        hit_beat();
        repeat (39) hit_beat();
        #2;
        AXIS_ARESETN = 1'b0;
        #1;
        chk("t1_start", START_TRG, 0);
        chk("t1_fin", FINALIZE_TRG, 0);
        chk("t1_busy", BUSY, 0);
        chk("t1_ev", EVENT_CNT, 0);
        chk("t1_drop", DROP_CNT, 0);
        chk("t1_ts", TIME_STAMP, 0);
        step(0, 0, 1, 1, 0);
        AXIS_ARESETN = 1'b1;

        // Sparse beats with 3-cycle gaps, window opened at ts 0xFFFF across the wrap.
        for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) idle_beat();
        hit_beat();
        chk("t6_stamp", TIME_STAMP, 16'hFFFF);
        n = 0;
        k = 0;
        while (START_TRG && k < 400) begin
            k++;
            step(0, 0, 0, 1, 0);
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
            if (START_TRG) n++;
            idle_beat();
        end
        chk("t6_beats", n, 39);
        chk("t6_stamp_hold", TIME_STAMP, 16'hFFFF);
        chk("t6_ev", EVENT_CNT, 1);
        wait_idle();

        finish_run();
    end

endmodule
